// File: rtl/uart_rx_byte_buffer.sv
// uart_rx_byte_buffer: assembles UART Rx bits into bytes and queues good frames in a FWFT FIFO.
// Define UART_RX_ERR_CNT_EN to build the saturating framing-error counter.
module uart_rx_byte_buffer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_catch_bit,
    input  logic [3:0]        i_catch_bit_cnt,
    input  logic              i_shift_rst,
    input  logic              i_rx_complete,
    input  logic              i_rx_error,
    input  logic              i_rx_ready,
    input  logic              i_overrun_clr,
    input  logic              i_err_clr,
    output logic [7:0]        o_rx_data,
    output logic              o_rx_valid,
    output logic [ADDR_W:0]   o_fifo_level,
    output logic              o_overrun,
    output logic [7:0]        o_err_cnt
);
    logic [7:0]        asm_q;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic              overrun;
    logic              push_req;
    logic              pop;
    logic              full;
    logic              push;

    // an error pulse vetoes a simultaneous complete
    always_comb begin
        push_req = i_rx_complete && !i_rx_error;
        pop      = o_rx_valid && i_rx_ready;
        full     = level == (ADDR_W+1)'(FIFO_DEPTH);
        push     = push_req && (!full || pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            asm_q <= '0;
        else if (i_shift_rst)
            asm_q <= '0;
        else if (!i_catch_bit_cnt[3])
            asm_q[i_catch_bit_cnt[2:0]] <= i_catch_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= asm_q;
                wr_ptr      <= wr_ptr + ADDR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            if (push != pop)
                level <= push ? level + (ADDR_W+1)'(1) : level - (ADDR_W+1)'(1);
            if (push_req && full && !pop)
                overrun <= 1'b1;
            else if (i_overrun_clr)
                overrun <= 1'b0;
        end
    end

    assign o_rx_data    = mem[rd_ptr];
    assign o_rx_valid   = level != '0;
    assign o_fifo_level = level;
    assign o_overrun    = overrun;

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (i_err_clr)
            err_cnt <= {7'd0, i_rx_error};
        else if (i_rx_error && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end

    assign o_err_cnt = err_cnt;
`else
    logic unused_err_clr;
    assign unused_err_clr = i_err_clr;
    assign o_err_cnt      = '0;
`endif
endmodule

// File: doc/uart_rx_byte_buffer.md
# uart_rx_byte_buffer

Receive-side byte assembler and output FIFO that sits directly downstream of the UART Rx bit-decision FSM (115200 baud, 16x oversampling). It builds each 8-bit frame from the FSM's per-bit decisions and commits the byte to a small first-word-fall-through FIFO only when the FSM reports a good stop bit. Error frames are discarded, and overflow is flagged. The block hands bytes to the consumer over a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..16.
- ADDR_W, 2, pointer width; must equal log2(FIFO_DEPTH).

- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- i_catch_bit  input  1  majority-voted data bit from the Rx FSM.
- i_catch_bit_cnt  input  4  bit index of i_catch_bit (0 = LSB).
- i_shift_rst  input  1  high while the Rx FSM is idle; clears the assembly register.
- i_rx_complete  input  1  one-cycle pulse: frame received, stop bit good.
- i_rx_error  input  1  one-cycle pulse: stop bit bad, frame invalid.
- i_rx_ready  input  1  consumer accepts the head byte.
- i_overrun_clr  input  1  clears o_overrun.
- i_err_clr  input  1  clears o_err_cnt; used only with UART_RX_ERR_CNT_EN.
- o_rx_data  output  8  head-of-FIFO byte; valid when o_rx_valid is high.
- o_rx_valid  output  1  FIFO not empty.
- o_fifo_level  output  ADDR_W+1  number of occupied entries.
- o_overrun  output  1  sticky flag: a good byte was dropped because the FIFO was full.
- o_err_cnt  output  8  count of framing errors.

## Operation
- Assembly register asm[7:0]:
  - While i_shift_rst = 1: asm <= 0.
  - Otherwise, every cycle: asm[i_catch_bit_cnt] <= i_catch_bit when i_catch_bit_cnt <= 7.
  - Index values 8..15 are ignored.
- Push: on i_rx_complete, write asm to the FIFO at the write pointer.
  - i_rx_complete and i_rx_error are mutually exclusive by construction. If both are seen high, treat the cycle as an error and push nothing.
- Pop: when o_rx_valid and i_rx_ready are both high, advance the read pointer.
- Full FIFO and push:
  - With a pop in the same cycle: the push is accepted and the level is unchanged.
  - Without a pop: the byte is dropped and o_overrun <= 1.
- Empty FIFO and pop: impossible, since o_rx_valid = 0.
- Push and pop in the same cycle on a non-full FIFO: the level is unchanged.
- Pointers are ADDR_W bits wide and wrap modulo FIFO_DEPTH. Level is tracked in a separate ADDR_W+1-bit counter, so full and empty are unambiguous.
- o_overrun: sticky. i_overrun_clr clears it. If a set and a clear occur in the same cycle, the set wins.
- i_rx_error: the frame is discarded. FIFO state is untouched.

## Timing
- Reset values: o_rx_data = 0, o_rx_valid = 0, o_fifo_level = 0, o_overrun = 0, o_err_cnt = 0. asm and both pointers are 0.
- asm bit update: 1 cycle after the i_catch_bit / i_catch_bit_cnt change.
- Push latency:
  - i_rx_complete high in cycle N -> o_fifo_level incremented and o_rx_valid = 1 in cycle N+1.
  - If the FIFO was empty, o_rx_data is the new byte in cycle N+1 (first-word fall-through, registered read).
- Pop: handshake in cycle N -> next entry, or o_rx_valid = 0, in cycle N+1.
- o_rx_data is stable while o_rx_valid = 1 and i_rx_ready = 0.
- Sustained throughput: one byte per cycle on both the push and pop sides.
- Reset asserted mid-operation: all state returns to the reset values immediately, and all FIFO contents are lost.

## Configuration
- UART_RX_ERR_CNT_EN, when defined:
  - o_err_cnt increments on each i_rx_error and saturates at 255.
  - i_err_clr clears the count. If a clear and an increment occur in the same cycle, the result is 1.
- When undefined: o_err_cnt is tied to 0, i_err_clr is ignored, and no counter register is built.

## Test plan
- Bits 0..7 = 1,0,1,0,0,1,0,1 (indices 0..7), then i_rx_complete -> next cycle o_rx_valid = 1, o_rx_data = 8'hA5, o_fifo_level = 1.
- Push 0x11, 0x22, 0x33 with i_rx_ready = 0, then hold i_rx_ready = 1 -> o_rx_data sequence 0x11, 0x22, 0x33, then o_rx_valid = 0.
- With depth 4, push 5 bytes and no pop -> o_fifo_level = 4, o_overrun = 1, FIFO holds the first 4 bytes. Assert i_overrun_clr -> o_overrun = 0.
- FIFO full, i_rx_complete and a pop in the same cycle -> level stays 4, the new byte is stored last, o_overrun stays 0.
- i_rx_error pulse after 8 bits -> no push, level unchanged. With UART_RX_ERR_CNT_EN, o_err_cnt = 1; after 300 errors, o_err_cnt = 255.
- rst_n low with 3 entries queued -> all outputs 0. Then i_shift_rst high -> asm = 0 before the next frame.
